vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous pixel memory between two requesters:
  - the VGA scanout fetcher, which reads bursts of pixels for the next line during blanking;
  - a drawing/CPU writer, which issues single-word writes.
- Sits between the pixel-clock timing/display logic and the frame-buffer RAM.
- Fetch has priority because it carries a display deadline.
- The writer gets a guaranteed slot after every burst, so it cannot starve.

Parameters:
- ADDR_W, 17, width of memory word address; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 12, pixel word width (4:4:4 RGB).
- LEN_W, 10, width of burst length field; maximum burst is 2^LEN_W-1 words.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  level request for a read burst; hold until fetch_ack.
- fetch_addr  in  ADDR_W  burst start address; sampled at acceptance.
- fetch_len  in  LEN_W  burst length in words; sampled at acceptance.
- fetch_ack  out  1  one-cycle pulse: burst accepted.
- fetch_dvalid  out  1  fetch_data valid this cycle.
- fetch_data  out  DATA_W  read pixel, in address order.
- fetch_done  out  1  one-cycle pulse marking end of burst.
- wr_valid  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- busy  out  1  high while a burst is in progress (state FETCH).
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read (mem_en=1, mem_we=0).

Behaviour:

States:
- IDLE, FETCH.
- Registered: cur_addr, remaining, grace flag.

Reset:
- Asynchronous; takes effect immediately, mid-burst included.
- State returns to IDLE, grace=0.
- All outputs are 0: fetch_ack, fetch_dvalid, fetch_data, fetch_done, wr_ready, busy, mem_en, mem_we, mem_addr, mem_wdata.
- No fetch_done is issued for an aborted burst.

IDLE, write grant:
- wr_ready = !rst && (state==IDLE) && (!fetch_req || grace).
- wr_ready is combinational and does not depend on wr_valid.

IDLE, fetch accept:
- Condition: fetch_req && !(grace && wr_valid).
- Pulse fetch_ack.
- Latch cur_addr=fetch_addr and remaining=fetch_len.
- If fetch_len!=0, go to FETCH.
- If fetch_len==0, stay in IDLE and pulse fetch_done the next cycle; no RAM access and no fetch_dvalid.

Grace flag:
- Set on the cycle FETCH exits.
- Cleared after the first IDLE cycle, whether or not a write occurred.
- Effect: one write slot is guaranteed between consecutive bursts.

FETCH:
- The first read issues the cycle after fetch_ack.
- Each cycle: mem_en=1, mem_we=0, mem_addr=cur_addr.
- Then cur_addr+1 (wrapping 2^ADDR_W-1 -> 0) and remaining-1.
- The cycle that issues remaining==1 is the last; next state is IDLE.
- wr_ready=0 throughout FETCH.

Read return:
- fetch_dvalid is a registered copy of (read issued); fetch_data = mem_rdata in that cycle.
- Latency is 1 cycle from issue.
- fetch_done is asserted together with the last fetch_dvalid.
- A granted write in the first IDLE cycle after FETCH overlaps that last return; this is legal, because RAM read data is already in flight.

Write:
- When wr_valid && wr_ready: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, all in the same cycle.
- Single-cycle operation, no write response.

Idle, no access:
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Simultaneous requests:
- In IDLE with fetch_req and wr_valid both high: the fetch wins, unless grace is set.
- When the write wins, the fetch is accepted the following cycle.

Other rules:
- fetch_req, fetch_addr and fetch_len changing during FETCH are ignored.
- Burst throughput is 1 word/cycle; a burst of N occupies N+1 cycles from ack to done.

Test Plan:
1. Basic burst: reset, preload RAM[100..103]=0x111,0x222,0x333,0x444; fetch_req with addr=100, len=4 -> fetch_ack at T, reads of 100..103 at T+1..T+4, fetch_dvalid at T+2..T+5 with data 0x111..0x444, fetch_done at T+5 only, busy high T+1..T+4.
2. Write-only traffic: wr_valid with addr=5, data=0xABC, fetch idle -> wr_ready=1; mem_we=1, mem_addr=5 same cycle; a later burst at addr=5, len=1 returns 0xABC.
3. Priority and grace: wr_valid held high while fetch_req is held for two back-to-back len=3 bursts -> wr_ready=0 during the first request and FETCH; exactly one write is granted in the first IDLE cycle; the second fetch_ack follows one cycle later.
4. Wrap-around: ADDR_W=17, fetch addr=0x1FFFE, len=4 -> mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
5. Zero length: fetch len=0 -> fetch_ack pulse, no mem_en, no fetch_dvalid, fetch_done one cycle after ack.
6. Reset mid-burst: assert rst during the 3rd read of a len=8 burst -> all outputs 0 immediately, no fetch_done; after release, a new len=2 burst completes normally.

Source files
------------

// File: rtl/vga_fb_if.sv
// Bundle of the fetch, write and frame-buffer RAM signals around vga_fb_arbiter.
// The slave modport is the arbiter side; master is the requester/RAM side.
interface vga_fb_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int LEN_W  = 10
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [LEN_W-1:0]  fetch_len;
  logic              fetch_ack;
  logic              fetch_dvalid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_done;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, fetch_len, wr_valid, wr_addr, wr_data, mem_rdata,
    output fetch_ack, fetch_dvalid, fetch_data, fetch_done, wr_ready, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, fetch_len, wr_valid, wr_addr, wr_data, mem_rdata,
    input  fetch_ack, fetch_dvalid, fetch_data, fetch_done, wr_ready, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout burst reads have priority, and one
// write slot is guaranteed in the first idle cycle after every burst.
//
// state | meaning
// IDLE  | serve single writes; accept a fetch burst (fetch wins unless grace)
// FETCH | issue one read per cycle until the burst length is exhausted
module vga_fb_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int LEN_W  = 10
) (
  input  logic        pclk,
  input  logic        rst,
  vga_fb_if.slave     bus
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              grace_q, grace_d;
  logic              dvalid_q, dvalid_d;
  logic              done_q, done_d;
  logic              accept;
  logic              wr_grant;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      grace_q     <= 1'b0;
      dvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      grace_q     <= grace_d;
      dvalid_q    <= dvalid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    grace_d       = grace_q;
    dvalid_d      = 1'b0;
    done_d        = 1'b0;
    accept        = 1'b0;
    wr_grant      = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        // grace only survives a single idle cycle, used or not
        grace_d      = 1'b0;
        bus.wr_ready = !rst && (!bus.fetch_req || grace_q);
        wr_grant     = bus.wr_ready && bus.wr_valid;
        accept       = !rst && bus.fetch_req && !(grace_q && bus.wr_valid);
        if (wr_grant) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.wr_addr;
          bus.mem_wdata = bus.wr_data;
        end
        if (accept) begin
          cur_addr_d  = bus.fetch_addr;
          remaining_d = bus.fetch_len;
          if (bus.fetch_len != '0) state_d = FETCH;
          else                     done_d  = 1'b1;
        end
      end
      FETCH: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = cur_addr_q;
        dvalid_d     = 1'b1;
        cur_addr_d   = cur_addr_q + ADDR_ONE;
        remaining_d  = remaining_q - LEN_ONE;
        if (remaining_q == LEN_ONE) begin
          state_d = IDLE;
          grace_d = 1'b1;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus.fetch_ack    = accept;
    bus.busy         = (state_q == FETCH);
    bus.fetch_dvalid = dvalid_q;
    bus.fetch_done   = done_q;
    bus.fetch_data   = dvalid_q ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios plus randomized
// write/burst traffic checked against a shadow memory and burst timing rules.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int LEN_W  = 10;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  vga_fb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  // RAM behaviour seen by the arbiter: synchronous single port, 1-cycle read
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge pclk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // what the bench believes memory holds, from its own accepted writes
  logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    @(negedge pclk);
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== a || bus.mem_wdata !== d) begin
      errors++;
      $display("FAIL write got rdy=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 %h %h",
               bus.wr_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, a, d);
    end
    shadow[a] = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  // burst of len words from a; optional write held high throughout, which
  // must lose at accept and win the first idle cycle after the burst
  task automatic do_burst(input logic [ADDR_W-1:0] a, input int len, input bit hold_wr,
                          input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    int expq[$];
    int e;
    logic [ADDR_W-1:0] ia;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    bus.fetch_len  = LEN_W'(len);
    bus.wr_valid   = hold_wr;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    @(negedge pclk);
    checks++;
    if (bus.fetch_ack !== 1'b1 || bus.wr_ready !== 1'b0 || bus.mem_en !== 1'b0 ||
        bus.busy !== 1'b0 || bus.fetch_done !== 1'b0) begin
      errors++;
      $display("FAIL burst_ack got ack=%b rdy=%b en=%b busy=%b done=%b want 1 0 0 0 0",
               bus.fetch_ack, bus.wr_ready, bus.mem_en, bus.busy, bus.fetch_done);
    end
    step();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = ADDR_W'($urandom);
    bus.fetch_len  = LEN_W'($urandom);
    for (int k = 0; k <= len; k++) begin
      @(negedge pclk);
      if (k < len) begin
        ia = a + ADDR_W'(k);
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 ||
            bus.mem_addr !== ia || bus.wr_ready !== 1'b0 || bus.fetch_ack !== 1'b0 ||
            bus.fetch_done !== 1'b0 || bus.fetch_dvalid !== (k > 0)) begin
          errors++;
          $display("FAIL burst_issue k=%0d got busy=%b en=%b we=%b addr=%h rdy=%b ack=%b done=%b dv=%b want 1 1 0 %h 0 0 0 %b",
                   k, bus.busy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.wr_ready,
                   bus.fetch_ack, bus.fetch_done, bus.fetch_dvalid, ia, (k > 0));
        end
        expq.push_back(shadow.exists(ia) ? int'(shadow[ia]) : -1);
      end else begin
        checks++;
        if (bus.busy !== 1'b0 || bus.fetch_done !== 1'b1 || bus.fetch_dvalid !== (len > 0) ||
            bus.fetch_ack !== 1'b0) begin
          errors++;
          $display("FAIL burst_done got busy=%b done=%b dv=%b ack=%b want 0 1 %b 0",
                   bus.busy, bus.fetch_done, bus.fetch_dvalid, bus.fetch_ack, (len > 0));
        end
        checks++;
        if (hold_wr) begin
          if (bus.wr_ready !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
              bus.mem_addr !== wa || bus.mem_wdata !== wd) begin
            errors++;
            $display("FAIL grace_write got rdy=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 %h %h",
                     bus.wr_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, wa, wd);
          end
          shadow[wa] = wd;
        end else if (bus.mem_en !== 1'b0) begin
          errors++;
          $display("FAIL burst_tail_idle got mem_en=%b want 0", bus.mem_en);
        end
      end
      if (k > 0) begin
        e = expq.pop_front();
        if (e >= 0) begin
          checks++;
          if (bus.fetch_dvalid !== 1'b1 || bus.fetch_data !== DATA_W'(e)) begin
            errors++;
            $display("FAIL burst_data k=%0d got dv=%b data=%h want 1 %h",
                     k, bus.fetch_dvalid, bus.fetch_data, DATA_W'(e));
          end
        end
      end
      step();
      if (k == len) bus.wr_valid = 1'b0;
    end
    @(negedge pclk);
    checks++;
    if (bus.fetch_done !== 1'b0 || bus.fetch_dvalid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_after got done=%b dv=%b busy=%b want 0 0 0",
               bus.fetch_done, bus.fetch_dvalid, bus.busy);
    end
    step();
  endtask

  task automatic test_reset();
    bus.fetch_req = 1'b1;
    bus.fetch_len = 10'd4;
    bus.wr_valid  = 1'b1;
    @(negedge pclk);
    checks++;
    if ({bus.fetch_ack, bus.fetch_dvalid, bus.fetch_data, bus.fetch_done, bus.wr_ready,
         bus.busy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b dv=%b en=%b we=%b rdy=%b addr=%h want all 0",
               bus.fetch_ack, bus.fetch_dvalid, bus.mem_en, bus.mem_we, bus.wr_ready, bus.mem_addr);
    end
    bus.fetch_req = 1'b0;
    bus.wr_valid  = 1'b0;
    step();
    rst = 1'b0;
    @(negedge pclk);
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b en=%b addr=%h want 1 0 0 0",
               bus.wr_ready, bus.busy, bus.mem_en, bus.mem_addr);
    end
    step();
  endtask

  task automatic test_basic_burst();
    do_write(17'd100, 12'h111);
    do_write(17'd101, 12'h222);
    do_write(17'd102, 12'h333);
    do_write(17'd103, 12'h444);
    do_burst(17'd100, 4, 1'b0, '0, '0);
  endtask

  task automatic test_write_only();
    do_write(17'd5, 12'hABC);
    do_burst(17'd5, 1, 1'b0, '0, '0);
  endtask

  task automatic test_priority_grace();
    logic [ADDR_W-1:0] a1, a2, w;
    logic [DATA_W-1:0] d;
    a1 = 17'd200;
    a2 = 17'd300;
    w  = 17'd400;
    d  = DATA_W'($urandom);
    for (int i = 0; i < 3; i++) begin
      do_write(a1 + ADDR_W'(i), DATA_W'($urandom));
      do_write(a2 + ADDR_W'(i), DATA_W'($urandom));
    end
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a1;
    bus.fetch_len  = 10'd3;
    bus.wr_valid   = 1'b1;
    bus.wr_addr    = w;
    bus.wr_data    = d;
    for (int c = 0; c <= 10; c++) begin
      @(negedge pclk);
      checks++;
      case (c)
        0, 5: if (bus.fetch_ack !== 1'b1 || bus.wr_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
          errors++;
          $display("FAIL prio_ack c=%0d got ack=%b rdy=%b en=%b want 1 0 0",
                   c, bus.fetch_ack, bus.wr_ready, bus.mem_en);
        end
        1, 2, 3, 6, 7, 8: if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.mem_addr !== ((c < 5) ? a1 + ADDR_W'(c - 1) : a2 + ADDR_W'(c - 6))) begin
          errors++;
          $display("FAIL prio_fetch c=%0d got busy=%b rdy=%b we=%b addr=%h",
                   c, bus.busy, bus.wr_ready, bus.mem_we, bus.mem_addr);
        end
        4: if (bus.fetch_ack !== 1'b0 || bus.wr_ready !== 1'b1 || bus.mem_we !== 1'b1 ||
               bus.mem_addr !== w || bus.mem_wdata !== d || bus.fetch_done !== 1'b1 ||
               bus.fetch_data !== shadow[a1 + 17'd2]) begin
          errors++;
          $display("FAIL prio_grace got ack=%b rdy=%b we=%b addr=%h wdata=%h done=%b data=%h want 0 1 1 %h %h 1 %h",
                   bus.fetch_ack, bus.wr_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   bus.fetch_done, bus.fetch_data, w, d, shadow[a1 + 17'd2]);
        end
        9: if (bus.fetch_done !== 1'b1 || bus.fetch_data !== shadow[a2 + 17'd2] ||
               bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL prio_done2 got done=%b data=%h rdy=%b busy=%b want 1 %h 1 0",
                   bus.fetch_done, bus.fetch_data, bus.wr_ready, bus.busy, shadow[a2 + 17'd2]);
        end
        default: if (bus.fetch_done !== 1'b0 || bus.fetch_ack !== 1'b0) begin
          errors++;
          $display("FAIL prio_idle got done=%b ack=%b want 0 0", bus.fetch_done, bus.fetch_ack);
        end
      endcase
      if (c == 4) shadow[w] = d;
      step();
      if (c == 0) bus.fetch_addr = a2;
      if (c == 5) begin
        bus.fetch_req = 1'b0;
        bus.wr_valid  = 1'b0;
      end
    end
  endtask

  task automatic test_wrap();
    do_write(17'h1FFFE, 12'h0A1);
    do_write(17'h1FFFF, 12'h0A2);
    do_write(17'h00000, 12'h0A3);
    do_write(17'h00001, 12'h0A4);
    do_burst(17'h1FFFE, 4, 1'b0, '0, '0);
  endtask

  task automatic test_zero_len();
    do_burst(17'd77, 0, 1'b0, '0, '0);
    do_burst(17'd78, 0, 1'b1, 17'd79, 12'h5A5);
  endtask

  task automatic test_reset_mid_burst();
    do_write(17'd16, 12'hC01);
    do_write(17'd17, 12'hC02);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 17'd500;
    bus.fetch_len  = 10'd8;
    @(negedge pclk);
    checks++;
    if (bus.fetch_ack !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ack got %b want 1", bus.fetch_ack);
    end
    step();
    bus.fetch_req = 1'b0;
    step();
    step();
    checks++;
    if (bus.mem_addr !== 17'd502 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_third_read got addr=%h busy=%b want 502 1", bus.mem_addr, bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.fetch_ack, bus.fetch_dvalid, bus.fetch_data, bus.fetch_done, bus.wr_ready,
         bus.busy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got dv=%b done=%b busy=%b en=%b addr=%h want all 0",
               bus.fetch_dvalid, bus.fetch_done, bus.busy, bus.mem_en, bus.mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++;
      if (bus.fetch_done !== 1'b0 || bus.fetch_dvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold got done=%b dv=%b en=%b want 0 0 0",
                 bus.fetch_done, bus.fetch_dvalid, bus.mem_en);
      end
      step();
    end
    rst = 1'b0;
    @(negedge pclk);
    checks++;
    if (bus.busy !== 1'b0 || bus.fetch_done !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release got busy=%b done=%b en=%b want 0 0 0",
               bus.busy, bus.fetch_done, bus.mem_en);
    end
    step();
    do_burst(17'd16, 2, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 32; i++) do_write(ADDR_W'(1000 + i), DATA_W'($urandom));
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      case (op)
        0: do_write(ADDR_W'(1000 + $urandom_range(0, 31)), DATA_W'($urandom));
        1: do_burst(ADDR_W'(1000 + $urandom_range(0, 24)), $urandom_range(0, 7), 1'b0, '0, '0);
        default: do_burst(ADDR_W'(1000 + $urandom_range(0, 24)), $urandom_range(0, 7), 1'b1,
                          ADDR_W'(1000 + $urandom_range(0, 31)), DATA_W'($urandom));
      endcase
    end
  endtask

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.fetch_len  = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    step();
    step();
    test_reset();
    test_basic_burst();
    test_write_only();
    test_priority_grace();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
